// File: rtl/pipeline_pkg.sv
// pipeline_pkg: opcodes, ALUOp encodings, control bundle and decode shared by the pipeline.
package pipeline_pkg;
   localparam int REG_IDX_W = 5;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;
   typedef struct packed {
      logic   reg_dst;
      logic   alu_src;
      logic   mem_to_reg;
      logic   reg_write;
      logic   mem_read;
      logic   mem_write;
      logic   branch;
      aluop_e alu_op;
   } ctrl_t;
   function automatic ctrl_t decode(input logic [5:0] op);
      ctrl_t c;
      c = '{default: '0, alu_op: ALUOP_ADD};
      case (op)
         OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_FUNCT; end
         OP_LW:    begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; end
         OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
         OP_BEQ:   begin c.branch = 1'b1; c.alu_op = ALUOP_SUB; end
         OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
         default:  c = '{default: '0, alu_op: ALUOP_ADD};
      endcase
      return c;
   endfunction
endpackage

// File: rtl/register_file.sv
// register_file: r0-hardwired register array, two combinational reads, one posedge write, async clear.
module register_file
   import pipeline_pkg::*;
#(
   parameter int REG_COUNT  = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we,
   input  logic [REG_IDX_W-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [REG_IDX_W-1:0]  raddr_a,
   input  logic [REG_IDX_W-1:0]  raddr_b,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b
);
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   always_comb begin
      regs_d = regs_q;
      if (we && waddr != '0) regs_d[waddr] = wdata;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   end
   assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode, register-file reads, and load-use stall/bubble generation.
module id_stage
   import pipeline_pkg::*;
#(
   parameter int REG_COUNT  = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           instruction_in,
   input  logic                  reg_write_wb,
   input  logic [REG_IDX_W-1:0]  write_reg_wb,
   input  logic [DATA_WIDTH-1:0] write_data_wb,
   input  logic                  mem_read_ex,
   input  logic [REG_IDX_W-1:0]  reg_dest_l_type_ex,
   output logic [DATA_WIDTH-1:0] data_a_out,
   output logic [DATA_WIDTH-1:0] data_b_out,
   output logic [DATA_WIDTH-1:0] sign_extend_out,
   output logic [10:0]           jump_dest_out,
   output logic [REG_IDX_W-1:0]  reg_dest_r_type_out,
   output logic [REG_IDX_W-1:0]  reg_dest_l_type_out,
   output logic                  RegDst_out,
   output logic                  ALUSrc_out,
   output logic                  MemToReg_out,
   output logic                  RegWrite_out,
   output logic                  MemRead_out,
   output logic                  MemWrite_out,
   output logic                  Branch_out,
   output logic [1:0]            ALUOp_out,
   output logic                  pc_write,
   output logic                  if_id_write
);
   logic [REG_IDX_W-1:0] rs, rt;
   logic                 stall;
   ctrl_t                ctrl;
   assign rs = instruction_in[25:21];
   assign rt = instruction_in[20:16];
   register_file #(.REG_COUNT(REG_COUNT), .DATA_WIDTH(DATA_WIDTH)) u_rf (
      .clock   (clock),
      .reset   (reset),
      .we      (reg_write_wb),
      .waddr   (write_reg_wb),
      .wdata   (write_data_wb),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (data_a_out),
      .rdata_b (data_b_out)
   );
   // Checks rt for every opcode; a spurious stall on a non-reading rt is harmless.
   always_comb begin
      stall = mem_read_ex && reg_dest_l_type_ex != '0 && (reg_dest_l_type_ex == rs || reg_dest_l_type_ex == rt);
      ctrl  = stall ? '{default: '0, alu_op: ALUOP_ADD} : decode(instruction_in[31:26]);
   end
   assign sign_extend_out     = {{(DATA_WIDTH-16){instruction_in[15]}}, instruction_in[15:0]};
   assign jump_dest_out       = instruction_in[10:0];
   assign reg_dest_r_type_out = instruction_in[15:11];
   assign reg_dest_l_type_out = rt;
   assign RegDst_out          = ctrl.reg_dst;
   assign ALUSrc_out          = ctrl.alu_src;
   assign MemToReg_out        = ctrl.mem_to_reg;
   assign RegWrite_out        = ctrl.reg_write;
   assign MemRead_out         = ctrl.mem_read;
   assign MemWrite_out        = ctrl.mem_write;
   assign Branch_out          = ctrl.branch;
   assign ALUOp_out           = ctrl.alu_op;
   assign pc_write            = !stall;
   assign if_id_write         = !stall;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a behavioural model.
module tb_id_stage;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instruction_in;
   logic        reg_write_wb;
   logic [4:0]  write_reg_wb;
   logic [31:0] write_data_wb;
   logic        mem_read_ex;
   logic [4:0]  reg_dest_l_type_ex;
   logic [31:0] data_a_out, data_b_out, sign_extend_out;
   logic [10:0] jump_dest_out;
   logic [4:0]  reg_dest_r_type_out, reg_dest_l_type_out;
   logic        RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out;
   logic [1:0]  ALUOp_out;
   logic        pc_write, if_id_write;
   logic [8:0]  ctrl_obs;
   logic [31:0] model_rf [32];
   int          passed = 0;
   int          total = 0;
   id_stage dut (
      .clock               (clock),
      .reset               (reset),
      .instruction_in      (instruction_in),
      .reg_write_wb        (reg_write_wb),
      .write_reg_wb        (write_reg_wb),
      .write_data_wb       (write_data_wb),
      .mem_read_ex         (mem_read_ex),
      .reg_dest_l_type_ex  (reg_dest_l_type_ex),
      .data_a_out          (data_a_out),
      .data_b_out          (data_b_out),
      .sign_extend_out     (sign_extend_out),
      .jump_dest_out       (jump_dest_out),
      .reg_dest_r_type_out (reg_dest_r_type_out),
      .reg_dest_l_type_out (reg_dest_l_type_out),
      .RegDst_out          (RegDst_out),
      .ALUSrc_out          (ALUSrc_out),
      .MemToReg_out        (MemToReg_out),
      .RegWrite_out        (RegWrite_out),
      .MemRead_out         (MemRead_out),
      .MemWrite_out        (MemWrite_out),
      .Branch_out          (Branch_out),
      .ALUOp_out           (ALUOp_out),
      .pc_write            (pc_write),
      .if_id_write         (if_id_write)
   );
   always #5 clock = ~clock;
   assign ctrl_obs = {RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, ALUOp_out};
   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [8:0] exp_ctrl(input logic [5:0] op, input logic st);
      logic [8:0] c;
      case (op)
         6'd0:    c = 9'b1001000_10;
         6'd35:   c = 9'b0111100_00;
         6'd43:   c = 9'b0100010_00;
         6'd4:    c = 9'b0000001_01;
         6'd8:    c = 9'b0101000_00;
         default: c = 9'b0000000_00;
      endcase
      return st ? 9'd0 : c;
   endfunction
   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      @(negedge clock);
      reg_write_wb = 1'b1; write_reg_wb = a; write_data_wb = d;
      @(posedge clock);
      #1;
      reg_write_wb = 1'b0;
      if (a != 0) model_rf[a] = d;
   endtask
   task automatic test_reset;
      reset = 1'b1; reg_write_wb = 1'b0; write_reg_wb = '0; write_data_wb = '0;
      mem_read_ex = 1'b0; reg_dest_l_type_ex = '0;
      instruction_in = mk_i(6'd0, 5'd1, 5'd2, 16'h1800);
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (data_a_out !== 32'd0 || data_b_out !== 32'd0)
         $display("FAIL reset_read: a=%h b=%h required 0/0", data_a_out, data_b_out);
      else passed++;
      @(negedge clock);
      reset = 1'b0;
   endtask
   task automatic test_r0;
      wb(5'd0, 32'hDEADBEEF);
      instruction_in = mk_i(6'd0, 5'd0, 5'd0, 16'h0000);
      #1;
      total++;
      if (data_a_out !== 32'd0 || data_b_out !== 32'd0)
         $display("FAIL r0_write: a=%h b=%h required 0/0", data_a_out, data_b_out);
      else passed++;
   endtask
   task automatic test_rtype_read;
      instruction_in = {6'd0, 5'd5, 5'd5, 5'd3, 5'd0, 6'h20};
      wb(5'd5, 32'h12345678);
      total++;
      if (data_a_out !== 32'h12345678 || data_b_out !== 32'h12345678)
         $display("FAIL rtype_read: a=%h b=%h required 12345678", data_a_out, data_b_out);
      else passed++;
      total++;
      if (ctrl_obs !== 9'b1001000_10 || reg_dest_r_type_out !== 5'd3)
         $display("FAIL rtype_ctrl: ctrl=%b rd=%0d required 100100010/3", ctrl_obs, reg_dest_r_type_out);
      else passed++;
   endtask
   task automatic test_lw;
      instruction_in = mk_i(6'd35, 5'd9, 5'd8, 16'hFFFC);
      #1;
      total++;
      if (sign_extend_out !== 32'hFFFFFFFC || reg_dest_l_type_out !== 5'd8)
         $display("FAIL lw_fields: sext=%h rt=%0d required fffffffc/8", sign_extend_out, reg_dest_l_type_out);
      else passed++;
      total++;
      if (ctrl_obs !== 9'b0111100_00)
         $display("FAIL lw_ctrl: ctrl=%b required 011110000", ctrl_obs);
      else passed++;
   endtask
   task automatic test_stall;
      instruction_in = {6'd0, 5'd8, 5'd2, 5'd1, 5'd0, 6'h20};
      mem_read_ex = 1'b1; reg_dest_l_type_ex = 5'd8;
      #1;
      total++;
      if (pc_write !== 1'b0 || if_id_write !== 1'b0 || ctrl_obs !== 9'd0)
         $display("FAIL stall_on: pc=%b ifid=%b ctrl=%b required 0/0/0", pc_write, if_id_write, ctrl_obs);
      else passed++;
      total++;
      if (reg_dest_r_type_out !== 5'd1)
         $display("FAIL stall_datapath: rd=%0d required 1", reg_dest_r_type_out);
      else passed++;
      mem_read_ex = 1'b0;
      #1;
      total++;
      if (pc_write !== 1'b1 || if_id_write !== 1'b1 || ctrl_obs !== 9'b1001000_10)
         $display("FAIL stall_off: pc=%b ifid=%b ctrl=%b required 1/1/100100010", pc_write, if_id_write, ctrl_obs);
      else passed++;
      mem_read_ex = 1'b1; reg_dest_l_type_ex = 5'd6;
      instruction_in = mk_i(6'd43, 5'd1, 5'd6, 16'h0010);
      wb(5'd6, 32'hCAFE0006);
      total++;
      if (pc_write !== 1'b0 || data_b_out !== 32'hCAFE0006)
         $display("FAIL stall_with_wb: pc=%b b=%h required 0/cafe0006", pc_write, data_b_out);
      else passed++;
      mem_read_ex = 1'b0;
   endtask
   task automatic test_no_stall_r0;
      mem_read_ex = 1'b1; reg_dest_l_type_ex = 5'd0;
      instruction_in = mk_i(6'd8, 5'd0, 5'd0, 16'h0001);
      #1;
      total++;
      if (pc_write !== 1'b1 || if_id_write !== 1'b1 || ctrl_obs !== 9'b0101000_00)
         $display("FAIL no_stall_r0: pc=%b ifid=%b ctrl=%b required 1/1/010100000", pc_write, if_id_write, ctrl_obs);
      else passed++;
      mem_read_ex = 1'b0;
      instruction_in = mk_i(6'h3F, 5'd3, 5'd4, 16'h1234);
      #1;
      total++;
      if (ctrl_obs !== 9'd0)
         $display("FAIL bad_opcode: ctrl=%b required 0", ctrl_obs);
      else passed++;
   endtask
   task automatic test_async_reset;
      wb(5'd7, 32'd5);
      instruction_in = mk_i(6'd4, 5'd7, 5'd7, 16'h0003);
      #1;
      total++;
      if (data_a_out !== 32'd5)
         $display("FAIL r7_before_reset: a=%h required 5", data_a_out);
      else passed++;
      #1;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      total++;
      if (data_a_out !== 32'd0 || data_b_out !== 32'd0)
         $display("FAIL async_reset: a=%h b=%h required 0/0", data_a_out, data_b_out);
      else passed++;
      total++;
      if (ctrl_obs !== 9'b0000001_01)
         $display("FAIL beq_ctrl: ctrl=%b required 000000101", ctrl_obs);
      else passed++;
      @(negedge clock);
      reset = 1'b0;
   endtask
   task automatic test_random;
      logic [5:0]  ops [6];
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic [15:0] imm;
      logic        st;
      ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd0};
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(1, 0) == 1) wb(5'($urandom_range(31, 0)), $urandom);
         op  = ($urandom_range(5, 0) == 5) ? 6'($urandom) : ops[$urandom_range(4, 0)];
         rs  = 5'($urandom); rt = 5'($urandom); imm = 16'($urandom);
         instruction_in = mk_i(op, rs, rt, imm);
         mem_read_ex = 1'($urandom);
         case ($urandom_range(3, 0))
            0: reg_dest_l_type_ex = rs;
            1: reg_dest_l_type_ex = rt;
            default: reg_dest_l_type_ex = 5'($urandom);
         endcase
         #1;
         st = mem_read_ex && reg_dest_l_type_ex != 0 && (reg_dest_l_type_ex == rs || reg_dest_l_type_ex == rt);
         total++;
         if (data_a_out !== model_rf[rs] || data_b_out !== model_rf[rt])
            $display("FAIL rnd_read[%0d]: a=%h b=%h required %h/%h", n, data_a_out, data_b_out, model_rf[rs], model_rf[rt]);
         else passed++;
         total++;
         if (sign_extend_out !== 32'(signed'(imm)) || jump_dest_out !== imm[10:0] || reg_dest_r_type_out !== imm[15:11] || reg_dest_l_type_out !== rt)
            $display("FAIL rnd_fields[%0d]: sext=%h jd=%h rd=%0d rt=%0d", n, sign_extend_out, jump_dest_out, reg_dest_r_type_out, reg_dest_l_type_out);
         else passed++;
         total++;
         if (ctrl_obs !== exp_ctrl(op, st) || pc_write !== !st || if_id_write !== !st)
            $display("FAIL rnd_ctrl[%0d]: ctrl=%b pc=%b ifid=%b required %b/%b", n, ctrl_obs, pc_write, if_id_write, exp_ctrl(op, st), !st);
         else passed++;
      end
      mem_read_ex = 1'b0;
   endtask
   initial begin
      test_reset;
      test_r0;
      test_rtype_read;
      test_lw;
      test_stall;
      test_no_stall_r0;
      test_async_reset;
      test_random;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
